mem_bus_bridge: RTL and testbench

MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

---
 rtl/mem_bus_bridge.sv | 143 ++++++++++++++
 tb/tb_mem_bus_bridge.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
// Core-to-SRAM bridge: accepts one sized load/store at a time, steers byte lanes,
// inserts configurable read wait states and flags misaligned accesses.
module mem_bus_bridge #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_rw,
    input  logic [1:0]  cpu_size,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_fault,
    output logic        sram_en,
    output logic        sram_we,
    output logic [29:0] sram_addr,
    output logic [3:0]  sram_be,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        FAULT
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] rdata_q, rdata_d;

    logic        misaligned;
    logic [3:0]  lane_be;
    logic [31:0] steered_wdata;
    logic [31:0] shifted_rdata;
    logic [31:0] load_data;

    assign misaligned = ((cpu_size == 2'd2) && cpu_addr[0]) ||
                        ((cpu_size == 2'd3) && (cpu_addr[1:0] != 2'b00));

    always_comb begin
        lane_be       = 4'b0000;
        steered_wdata = wdata_q;
        load_data     = shifted_rdata;
        case (size_q)
            2'd1: begin
                lane_be       = 4'b0001 << addr_q[1:0];
                steered_wdata = {4{wdata_q[7:0]}};
                load_data     = {24'd0, shifted_rdata[7:0]};
            end
            2'd2: begin
                lane_be       = addr_q[1] ? 4'b1100 : 4'b0011;
                steered_wdata = {2{wdata_q[15:0]}};
                load_data     = {16'd0, shifted_rdata[15:0]};
            end
            2'd3: begin
                lane_be       = 4'b1111;
            end
            default: begin
                lane_be       = 4'b0000;
            end
        endcase
    end

    // Loads are returned zero-filled; the core performs any sign extension.
    assign shifted_rdata = sram_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        size_d     = size_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_size != 2'd0) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    rw_d    = cpu_rw;
                    size_d  = cpu_size;
                    state_d = misaligned ? FAULT : ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = 4'd0;
                state_d    = rw_q ? DONE : WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    rdata_d = load_data;
                    state_d = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rw_q       <= 1'b0;
            size_q     <= 2'd0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            size_q     <= size_d;
            rdata_q    <= rdata_d;
        end
    end

    // Moore outputs decoded from state so reset clears them immediately.
    assign cpu_ready  = (state_q == DONE) || (state_q == FAULT);
    assign cpu_fault  = (state_q == FAULT);
    assign cpu_rdata  = rdata_q;
    assign sram_en    = (state_q == ISSUE);
    assign sram_we    = (state_q == ISSUE) && rw_q;
    assign sram_be    = (state_q == ISSUE) ? lane_be : 4'b0000;
    assign sram_addr  = addr_q[31:2];
    assign sram_wdata = steered_wdata;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Randomised scoreboard bench for mem_bus_bridge: a byte-addressed reference
// memory predicts responses and SRAM strobes; monitors compare on the falling edge.
module tb_mem_bus_bridge;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_rw = 1'b0;
    logic [1:0]  cpu_size = 2'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_fault;
    logic        sram_en;
    logic        sram_we;
    logic [29:0] sram_addr;
    logic [3:0]  sram_be;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    mem_bus_bridge #(.WAIT_STATES(WS)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rw     (cpu_rw),
        .cpu_size   (cpu_size),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .cpu_fault  (cpu_fault),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_be    (sram_be),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM behaviour: write lanes on the strobe, read data valid WS+1 cycles later.
    logic [31:0] sram_mem [0:255];
    logic [31:0] rd_pipe  [0:WS];

    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] = 32'd0;
    end

    always @(posedge clk) begin
        if (sram_en && sram_we) begin
            for (int l = 0; l < 4; l++)
                if (sram_be[l]) sram_mem[sram_addr[7:0]][8*l +: 8] <= sram_wdata[8*l +: 8];
        end
        rd_pipe[0] <= (sram_en && !sram_we) ? sram_mem[sram_addr[7:0]] : 32'h5A5A_5A5A;
        for (int i = 1; i <= WS; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign sram_rdata = rd_pipe[WS];

    typedef struct {
        int          acc;
        int          lat;
        logic        fault;
        logic [31:0] rdata;
        string       tag;
    } resp_t;

    typedef struct {
        int          acc;
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } sop_t;

    resp_t resp_q[$];
    sop_t  sop_q[$];

    logic [7:0]  ref_bytes [0:1023];
    logic [31:0] last_read = 32'd0;

    initial begin
        for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'd0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-granular memory, access size in bytes, plain arithmetic.
    task automatic expect_req(input int acc, input logic rw, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        resp_t       r;
        sop_t        s;
        int          n;
        int          a;
        logic [31:0] v;
        n = (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : 4;
        a = int'(addr);
        r.acc = acc;
        r.tag = tag;
        if ((a % n) != 0) begin
            r.fault = 1'b1;
            r.lat   = 1;
            r.rdata = last_read;
            resp_q.push_back(r);
            return;
        end
        s.acc   = acc;
        s.we    = rw;
        s.addr  = 30'(a / 4);
        s.be    = 4'b0000;
        s.wdata = 32'd0;
        for (int k = 0; k < n; k++) s.be[(a + k) % 4] = 1'b1;
        for (int l = 0; l < 4; l++) s.wdata[8*l +: 8] = wdata[8*(l % n) +: 8];
        sop_q.push_back(s);
        r.fault = 1'b0;
        if (rw) begin
            for (int k = 0; k < n; k++) ref_bytes[a + k] = wdata[8*k +: 8];
            r.lat   = 2;
            r.rdata = last_read;
        end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = ref_bytes[a + k];
            last_read = v;
            r.lat     = WS + 3;
            r.rdata   = v;
        end
        resp_q.push_back(r);
    endtask

    always @(negedge clk) begin : monitor
        resp_t r;
        sop_t  s;
        if (rst) begin
            check("fault_only_with_ready", {31'd0, cpu_fault & ~cpu_ready}, 32'd0);
            if (cpu_ready) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    r = resp_q.pop_front();
                    check({"latency ", r.tag}, 32'(cyc - r.acc + 1), 32'(r.lat));
                    check({"fault ", r.tag}, {31'd0, cpu_fault}, {31'd0, r.fault});
                    check({"rdata ", r.tag}, cpu_rdata, r.rdata);
                    $display("txn %s acc=%0d lat=%0d fault=%0b rdata=%h", r.tag, r.acc,
                             cyc - r.acc + 1, cpu_fault, cpu_rdata);
                end
            end
            if (sram_en) begin
                if (sop_q.size() == 0) begin
                    check("unexpected_sram_en", 32'd1, 32'd0);
                end else begin
                    s = sop_q.pop_front();
                    check("sram_en_cycle", 32'(cyc), 32'(s.acc));
                    check("sram_we", {31'd0, sram_we}, {31'd0, s.we});
                    check("sram_addr", {2'd0, sram_addr}, {2'd0, s.addr});
                    check("sram_be", {28'd0, sram_be}, {28'd0, s.be});
                    if (s.we) check("sram_wdata", sram_wdata, s.wdata);
                end
            end else begin
                check("strobes_idle", {27'd0, sram_we, sram_be}, 32'd0);
            end
        end
    end

    task automatic summary_and_finish();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Entered on a falling edge with the bridge idle, or (b2b) with ready showing.
    task automatic issue(input logic rw, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit b2b, input string tag);
        int acc;
        int guard;
        acc       = b2b ? cyc + 2 : cyc + 1;
        cpu_rw    = rw;
        cpu_size  = size;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        expect_req(acc, rw, size, addr, wdata, tag);
        guard = 0;
        @(negedge clk);
        while (!(cpu_ready && cyc >= acc)) begin
            if (cyc >= acc) begin
                cpu_rw    = 1'($urandom);
                cpu_size  = 2'($urandom);
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
            end
            guard++;
            if (guard > 60) begin
                errors++;
                $display("FAIL timeout %s: got no ready required ready within 60 cycles", tag);
                summary_and_finish();
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        cpu_size = 2'd0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({"rst_ready ", tag}, {31'd0, cpu_ready}, 32'd0);
        check({"rst_fault ", tag}, {31'd0, cpu_fault}, 32'd0);
        check({"rst_en_we_be ", tag}, {26'd0, sram_en, sram_we, sram_be}, 32'd0);
        check({"rst_addr ", tag}, {2'd0, sram_addr}, 32'd0);
        check({"rst_wdata ", tag}, sram_wdata, 32'd0);
        check({"rst_rdata ", tag}, cpu_rdata, 32'd0);
    endtask

    initial begin
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;

        repeat (3) @(negedge clk);
        check_all_zero("initial");
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        issue(1'b1, 2'd3, 32'h100, 32'hDEAD_BEEF, 1'b0, "word_write_100");
        idle(1);
        issue(1'b1, 2'd3, 32'h100, 32'h1122_3344, 1'b0, "word_write_100b");
        idle(1);
        issue(1'b0, 2'd1, 32'h103, 32'd0, 1'b0, "byte_read_103");
        check("byte_read_103_value", cpu_rdata, 32'h0000_0011);
        idle(2);
        issue(1'b1, 2'd2, 32'h102, 32'h0000_ABCD, 1'b0, "half_write_102");
        idle(1);
        issue(1'b0, 2'd2, 32'h102, 32'd0, 1'b0, "half_read_102");
        check("half_read_102_value", cpu_rdata, 32'h0000_ABCD);
        idle(1);
        issue(1'b0, 2'd3, 32'h101, 32'd0, 1'b0, "misaligned_word_101");
        idle(1);
        issue(1'b1, 2'd2, 32'h003, 32'h1234_5678, 1'b0, "misaligned_half_003");
        idle(1);
        issue(1'b1, 2'd3, 32'h200, 32'hCAFE_F00D, 1'b0, "b2b_write_200");
        issue(1'b0, 2'd3, 32'h200, 32'd0, 1'b1, "b2b_read_200");
        check("b2b_read_200_value", cpu_rdata, 32'hCAFE_F00D);
        idle(1);

        // Reset while the read is sitting in its wait states.
        cpu_rw   = 1'b0;
        cpu_size = 2'd3;
        cpu_addr = 32'h100;
        expect_req(cyc + 1, 1'b0, 2'd3, 32'h100, 32'd0, "aborted_read");
        @(negedge clk);
        cpu_size = 2'd0;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("mid_wait");
        resp_q.delete();
        last_read = 32'd0;
        repeat (2) @(negedge clk);
        check_all_zero("held");
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        issue(1'b0, 2'd3, 32'h100, 32'd0, 1'b0, "read_after_reset");

        for (int t = 0; t < 300; t++) begin
            rw    = 1'($urandom);
            size  = 2'($urandom_range(1, 3));
            addr  = 32'($urandom_range(0, 1023));
            wdata = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                issue(rw, size, addr, wdata, 1'b1, $sformatf("rand%0d_b2b", t));
            end else begin
                idle($urandom_range(1, 3));
                issue(rw, size, addr, wdata, 1'b0, $sformatf("rand%0d", t));
            end
        end

        idle(4);
        check("resp_queue_empty", 32'(resp_q.size()), 32'd0);
        check("sop_queue_empty", 32'(sop_q.size()), 32'd0);
        summary_and_finish();
    end

endmodule
